// File: rtl/snake_pkg.sv
// Shared definitions for the snake game: FSM states, playfield limits, apple size,
// score width and small geometry helpers used by the points counter and its neighbours.
package snake_pkg;

  typedef enum logic [1:0] {
    StArmed,
    StHit,
    StRespawn,
    StWon
  } state_e;

  localparam int unsigned SCREEN_W    = 1280;
  localparam int unsigned SCREEN_H    = 1024;
  localparam int unsigned APPLE_SIZE  = 32;
  // The apple must fit entirely on screen, and the top band is reserved for the scoreboard.
  localparam int unsigned FIELD_X_MAX = SCREEN_W - APPLE_SIZE;
  localparam int unsigned FIELD_Y_MIN = 2 * APPLE_SIZE;
  localparam int unsigned FIELD_Y_MAX = SCREEN_H - APPLE_SIZE;
  localparam int unsigned POINTS_W    = 6;
  localparam int unsigned COORD_W     = 11;

  // Two boxes of edge `size` overlap when both axis distances are below `size`.
  // Differences are taken as 12-bit signed so no unsigned wrap can fake a hit.
  function automatic logic box_overlap(input logic [COORD_W-1:0] ax,
                                       input logic [COORD_W-1:0] ay,
                                       input logic [COORD_W-1:0] bx,
                                       input logic [COORD_W-1:0] by,
                                       input int unsigned        size);
    logic signed [COORD_W:0] dx;
    logic signed [COORD_W:0] dy;
    logic        [COORD_W:0] adx;
    logic        [COORD_W:0] ady;
    dx  = $signed({1'b0, ax}) - $signed({1'b0, bx});
    dy  = $signed({1'b0, ay}) - $signed({1'b0, by});
    adx = dx[COORD_W] ? $unsigned(-dx) : $unsigned(dx);
    ady = dy[COORD_W] ? $unsigned(-dy) : $unsigned(dy);
    return (32'(adx) < size) && (32'(ady) < size);
  endfunction

  // Legal apple placement region inside the playfield.
  function automatic logic in_field(input logic [COORD_W-1:0] x,
                                    input logic [COORD_W-1:0] y);
    return (32'(x) <= FIELD_X_MAX) && (32'(y) >= FIELD_Y_MIN) && (32'(y) <= FIELD_Y_MAX);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR (taps 16'hB400), loaded with `seed` on reset.
module lfsr16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Shift right, folding the dropped bit back in through the tap mask.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  // State register with synchronous reload of the seed.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/points_counter.sv
// Score keeper for the snake game: detects the head eating the apple once per frame,
// counts points up to a win threshold and respawns the apple at a pseudo-random spot.
module points_counter #(
  parameter int unsigned MAX_POINTS   = 16,
  parameter int unsigned APPLE_SIZE   = snake_pkg::APPLE_SIZE,
  parameter int unsigned APPLE_INIT_X = 640,
  parameter int unsigned APPLE_INIT_Y = 512,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             game_en,
  input  logic                             frame_tick,
  input  logic [snake_pkg::COORD_W-1:0]    head_x,
  input  logic [snake_pkg::COORD_W-1:0]    head_y,
  output logic [snake_pkg::COORD_W-1:0]    apple_x,
  output logic [snake_pkg::COORD_W-1:0]    apple_y,
  output logic [snake_pkg::POINTS_W-1:0]   points,
  output logic                             eat_pulse,
  output logic                             game_won
);

  import snake_pkg::*;

  localparam int unsigned             MaxRetries = 16;
  localparam logic [POINTS_W-1:0]     MaxPts     = POINTS_W'(MAX_POINTS);
  localparam logic [COORD_W-1:0]      InitX      = COORD_W'(APPLE_INIT_X);
  localparam logic [COORD_W-1:0]      InitY      = COORD_W'(APPLE_INIT_Y);
  localparam logic [3:0]              LastRetry  = 4'(MaxRetries - 1);

  state_e              state_q, state_d;
  logic [POINTS_W-1:0] points_q, points_d;
  logic                eat_q, eat_d;
  logic                won_q, won_d;
  logic [COORD_W-1:0]  apple_x_q, apple_x_d;
  logic [COORD_W-1:0]  apple_y_q, apple_y_d;
  logic [3:0]          retry_q, retry_d;

  logic [15:0]         lfsr_val;
  logic [COORD_W-1:0]  cand_x;
  logic [COORD_W-1:0]  cand_y;
  logic                head_on_apple;
  logic                cand_ok;
  logic [POINTS_W-1:0] points_inc;

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (LFSR_SEED),
    .q    (lfsr_val)
  );

  // Candidate position and acceptance tests derived from the current LFSR state.
  always_comb begin
    cand_x        = lfsr_val[10:0];
    cand_y        = {1'b0, lfsr_val[15:6]};
    head_on_apple = box_overlap(head_x, head_y, apple_x_q, apple_y_q, APPLE_SIZE);
    cand_ok       = in_field(cand_x, cand_y) &&
                    !box_overlap(head_x, head_y, cand_x, cand_y, APPLE_SIZE);
    points_inc    = (points_q >= MaxPts) ? points_q : points_q + 1'b1;
  end

  // Next-state and registered-output logic for the eat / respawn FSM.
  always_comb begin
    state_d   = state_q;
    points_d  = points_q;
    eat_d     = 1'b0;
    won_d     = won_q;
    apple_x_d = apple_x_q;
    apple_y_d = apple_y_q;
    retry_d   = retry_q;
    unique case (state_q)
      StArmed: begin
        if (frame_tick && game_en && head_on_apple) begin
          state_d = StHit;
        end
      end
      StHit: begin
        points_d = points_inc;
        eat_d    = 1'b1;
        retry_d  = '0;
        if (points_inc == MaxPts) begin
          state_d = StWon;
          won_d   = 1'b1;
        end else begin
          state_d = StRespawn;
        end
      end
      StRespawn: begin
        if (cand_ok) begin
          apple_x_d = cand_x;
          apple_y_d = cand_y;
          retry_d   = '0;
          state_d   = StArmed;
        end else if (retry_q == LastRetry) begin
          // Give up on random placement; the fallback spot skips the head check.
          apple_x_d = InitX;
          apple_y_d = InitY;
          retry_d   = '0;
          state_d   = StArmed;
        end else begin
          retry_d = retry_q + 4'd1;
        end
      end
      StWon: begin
        state_d = StWon;
      end
      default: begin
        state_d = StArmed;
      end
    endcase
  end

  // State registers; reset wins over every in-flight event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StArmed;
      points_q  <= '0;
      eat_q     <= 1'b0;
      won_q     <= 1'b0;
      apple_x_q <= InitX;
      apple_y_q <= InitY;
      retry_q   <= '0;
    end else begin
      state_q   <= state_d;
      points_q  <= points_d;
      eat_q     <= eat_d;
      won_q     <= won_d;
      apple_x_q <= apple_x_d;
      apple_y_q <= apple_y_d;
      retry_q   <= retry_d;
    end
  end

  assign apple_x   = apple_x_q;
  assign apple_y   = apple_y_q;
  assign points    = points_q;
  assign eat_pulse = eat_q;
  assign game_won  = won_q;

endmodule
